// File: rtl/play_core.sv
// play_core: clip playback engine.
//   Reads the clip header word at the selected base address (low ADDR_W bits
//   hold the sample count N), then fetches samples base+1 .. base+N one at a
//   time over the SDRAM read/finished handshake and presents each one on the
//   audio valid/ready stream. The controller may pause (level) or stop (pulse).
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   play_start/select      start pulse and clip base address (accepted in IDLE only)
//   play_pause, play_stop  hold output while high / abort playback
//   play_done, play_busy   one pulse per accepted start / high while not IDLE
//   play_read, play_addr   SDRAM read request (held until finished), word address
//   play_readdata          SDRAM read data, valid with play_sdram_finished
//   play_write/writedata   unused write channel, tied low
//   play_audio_*           sample stream to the audio sink
module play_core #(
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_done,
  output logic              play_busy,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_readdata,
  output logic              play_write,
  output logic [DATA_W-1:0] play_writedata,
  input  logic              play_sdram_finished,
  output logic [DATA_W-1:0] play_audio_data,
  output logic              play_audio_valid,
  input  logic              play_audio_ready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    RD_DATA,
    SEND,
    PAUSED
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] length, length_n;
  logic [ADDR_W-1:0] count, count_n;
  logic [ADDR_W-1:0] count_inc;
  logic [ADDR_W-1:0] rd_len;
  logic [DATA_W-1:0] data_n;
  logic              stop_pend, stop_pend_n;
  logic              done_n;

  assign play_read        = (state == RD_LEN) || (state == RD_DATA);
  assign play_audio_valid = (state == SEND);
  assign play_busy        = (state != IDLE);
  assign play_write       = 1'b0;
  assign play_writedata   = '0;

  assign count_inc = count + ADDR_W'(1);
  assign rd_len    = play_readdata[ADDR_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      play_addr       <= '0;
      play_audio_data <= '0;
      length          <= '0;
      count           <= '0;
      stop_pend       <= 1'b0;
      play_done       <= 1'b0;
    end else begin
      state           <= state_n;
      play_addr       <= addr_n;
      play_audio_data <= data_n;
      length          <= length_n;
      count           <= count_n;
      stop_pend       <= stop_pend_n;
      play_done       <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = play_addr;
    data_n      = play_audio_data;
    length_n    = length;
    count_n     = count;
    stop_pend_n = stop_pend;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (play_start) begin
          state_n     = RD_LEN;
          addr_n      = play_select;
          count_n     = '0;
          stop_pend_n = 1'b0;
        end
      end

      // A stop during a read cannot cancel the SDRAM op; remember it and
      // retire once the read completes, discarding whatever came back.
      RD_LEN: begin
        if (play_stop) stop_pend_n = 1'b1;
        if (play_sdram_finished) begin
          length_n = rd_len;
          if (stop_pend || play_stop || rd_len == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n  = play_addr + ADDR_W'(1);
            state_n = RD_DATA;
          end
        end
      end

      RD_DATA: begin
        if (play_stop) stop_pend_n = 1'b1;
        if (play_sdram_finished) begin
          if (stop_pend || play_stop) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            data_n  = play_readdata;
            state_n = SEND;
          end
        end
      end

      // Transfer wins over stop and pause in the same cycle.
      SEND: begin
        if (play_audio_ready) begin
          count_n = count_inc;
          if (play_stop || count_inc == length) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n  = play_addr + ADDR_W'(1);
            state_n = RD_DATA;
          end
        end else if (play_stop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (play_pause) begin
          state_n = PAUSED;
        end
      end

      PAUSED: begin
        if (play_stop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (!play_pause) begin
          state_n = SEND;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_play_core.sv
// tb_play_core: self-checking bench for play_core.
//   Contains a behavioural SDRAM (associative memory with programmable read
//   latency), an audio sink with random/forced back-pressure, and a clip model
//   that lists the expected read addresses and sample sequence for each start.
module tb_play_core;

  localparam int AW = 23;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          play_start = 1'b0;
  logic [AW-1:0] play_select = '0;
  logic          play_pause = 1'b0;
  logic          play_stop = 1'b0;
  logic          play_done;
  logic          play_busy;
  logic          play_read;
  logic [AW-1:0] play_addr;
  logic [DW-1:0] play_readdata = '0;
  logic          play_write;
  logic [DW-1:0] play_writedata;
  logic          play_sdram_finished = 1'b0;
  logic [DW-1:0] play_audio_data;
  logic          play_audio_valid;
  logic          play_audio_ready = 1'b0;

  play_core #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .play_start          (play_start),
    .play_select         (play_select),
    .play_pause          (play_pause),
    .play_stop           (play_stop),
    .play_done           (play_done),
    .play_busy           (play_busy),
    .play_read           (play_read),
    .play_addr           (play_addr),
    .play_readdata       (play_readdata),
    .play_write          (play_write),
    .play_writedata      (play_writedata),
    .play_sdram_finished (play_sdram_finished),
    .play_audio_data     (play_audio_data),
    .play_audio_valid    (play_audio_valid),
    .play_audio_ready    (play_audio_ready)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- models and observation state ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] exp_tx[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] tx_q[$];

  int            done_cnt, viol, rcyc, vcnt;
  bit            in_flight;
  int            lat_cnt;
  logic [AW-1:0] raddr;
  bit            pend;
  logic [DW-1:0] pend_val;
  bit            prev_quiet;

  int            lat = 2;
  int            ready_pct = 100;
  int            pause_pct = 0;
  int            stop_cyc = -1;
  bit            stop_addr_en = 0;
  logic [AW-1:0] stop_addr = '0;
  logic [AW-1:0] hold_addr = '0;
  int            hold_left = 0;
  logic [AW-1:0] pause_addr = '0;
  int            pause_left = 0;
  bit            pause_on = 0;
  bit            busy_start_en = 0;

  // Build a clip in memory and the expected read/sample sequences.
  task automatic setup_clip(input logic [AW-1:0] base, input int n);
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    exp_rd.delete();
    exp_tx.delete();
    w = $urandom();
    w[AW-1:0] = AW'(n);
    mem[base] = w;
    exp_rd.push_back(base);
    for (int i = 1; i <= n; i++) begin
      a = base + AW'(i);
      w = $urandom();
      mem[a] = w;
      exp_rd.push_back(a);
      exp_tx.push_back(w);
    end
  endtask

  // One clock: observe just after the rising edge, then drive the next cycle.
  task automatic step();
    bit rdy, pz, tx;
    @(posedge i_clk);
    #1;
    rcyc++;
    if (play_done) done_cnt++;
    if (play_write !== 1'b0 || play_writedata !== '0) viol++;
    if (play_audio_valid && play_read) viol++;
    if (prev_quiet && play_audio_valid) viol++;
    if (play_audio_valid) vcnt++;

    // SDRAM: one request at a time, finished after 'lat' cycles.
    play_sdram_finished = 1'b0;
    play_readdata       = $urandom();
    if (in_flight) begin
      if (!play_read || play_addr !== raddr) viol++;
      lat_cnt--;
      if (lat_cnt == 0) begin
        play_sdram_finished = 1'b1;
        play_readdata       = mem.exists(raddr) ? mem[raddr] : '0;
        in_flight           = 1'b0;
      end
    end else if (play_read) begin
      in_flight = 1'b1;
      lat_cnt   = lat;
      raddr     = play_addr;
      rd_q.push_back(play_addr);
    end

    // Sink and controller.
    rdy = ($urandom_range(99) < ready_pct);
    pz  = ($urandom_range(99) < pause_pct);
    if (hold_left > 0 && play_audio_valid && play_addr == hold_addr) begin
      rdy = 1'b0;
      hold_left--;
    end
    if (pause_left > 0 && (pause_on || (play_audio_valid && play_addr == pause_addr))) begin
      pause_on = 1'b1;
      pz       = 1'b1;
      rdy      = 1'b0;
      pause_left--;
      if (pause_left == 0) pause_on = 1'b0;
    end

    tx = play_audio_valid && rdy;
    if (play_audio_valid) begin
      if (pend && play_audio_data !== pend_val) viol++;
      if (tx) begin
        tx_q.push_back(play_audio_data);
        pend = 1'b0;
      end else begin
        pend     = 1'b1;
        pend_val = play_audio_data;
      end
    end
    // Pause without a transfer in SEND, or pause held while paused, keeps valid low next cycle.
    prev_quiet = pz && !tx && (play_audio_valid || prev_quiet);

    play_stop = 1'b0;
    if (done_cnt == 0) begin
      if (stop_cyc >= 0 && rcyc == stop_cyc) play_stop = 1'b1;
      if (stop_addr_en && play_read && play_addr == stop_addr) begin
        play_stop    = 1'b1;
        stop_addr_en = 1'b0;
      end
    end
    if (busy_start_en && rcyc == 3) begin
      play_start  = 1'b1;
      play_select = ~play_select;
    end else begin
      play_start = 1'b0;
    end
    play_audio_ready = rdy;
    play_pause       = pz;
  endtask

  // Start a playback and check it against the clip model.
  task automatic play(input logic [AW-1:0] base, input string tag, input bit exact);
    int m;
    rd_q.delete();
    tx_q.delete();
    done_cnt = 0; viol = 0; rcyc = 0; vcnt = 0;
    pend = 1'b0; prev_quiet = 1'b0;
    play_select = base;
    play_start  = 1'b1;
    step();
    chk({tag, ".read_after_start"}, play_read, 1);
    chk({tag, ".addr_after_start"}, play_addr, base);
    while (done_cnt == 0 && rcyc < 3000) step();
    chk({tag, ".done_seen"}, (done_cnt != 0), 1);
    repeat (4) step();
    chk({tag, ".done_once"}, done_cnt, 1);
    chk({tag, ".busy_end"}, play_busy, 0);
    chk({tag, ".valid_end"}, play_audio_valid, 0);
    chk({tag, ".read_end"}, play_read, 0);
    chk({tag, ".protocol"}, viol, 0);
    if (exact) begin
      chk({tag, ".n_reads"}, rd_q.size(), exp_rd.size());
      chk({tag, ".n_samples"}, tx_q.size(), exp_tx.size());
    end else begin
      chk({tag, ".reads_prefix"}, (rd_q.size() <= exp_rd.size()), 1);
      chk({tag, ".samples_prefix"}, (tx_q.size() <= exp_tx.size()), 1);
    end
    m = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < m; i++) chk({tag, ".rd_addr"}, rd_q[i], exp_rd[i]);
    m = (tx_q.size() < exp_tx.size()) ? tx_q.size() : exp_tx.size();
    for (int i = 0; i < m; i++) chk({tag, ".sample"}, tx_q[i], exp_tx[i]);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            lat;
    int            rp;
    int            pp;
    int            exp_reads;
    int            exp_samples;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] base;
    bit            ex;

    tbl[0] = '{base: 23'd100,      n: 3, lat: 2, rp: 100, pp: 0,  exp_reads: 4, exp_samples: 3};
    tbl[1] = '{base: 23'd200,      n: 0, lat: 2, rp: 100, pp: 0,  exp_reads: 1, exp_samples: 0};
    tbl[2] = '{base: 23'h7FFFFE,   n: 4, lat: 1, rp: 100, pp: 0,  exp_reads: 5, exp_samples: 4};
    tbl[3] = '{base: 23'd300,      n: 5, lat: 4, rp: 50,  pp: 0,  exp_reads: 6, exp_samples: 5};
    tbl[4] = '{base: 23'd400,      n: 1, lat: 3, rp: 100, pp: 20, exp_reads: 2, exp_samples: 1};
    tbl[5] = '{base: 23'd500,      n: 6, lat: 1, rp: 70,  pp: 15, exp_reads: 7, exp_samples: 6};

    // Reset state.
    #1;
    chk("rst.busy", play_busy, 0);
    chk("rst.read", play_read, 0);
    chk("rst.valid", play_audio_valid, 0);
    chk("rst.done", play_done, 0);
    chk("rst.addr", play_addr, 0);
    chk("rst.data", play_audio_data, 0);
    chk("rst.write", play_write, 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Table-driven clips (first two are the basic clip and the empty clip).
    for (int i = 0; i < 6; i++) begin
      lat = tbl[i].lat; ready_pct = tbl[i].rp; pause_pct = tbl[i].pp; stop_cyc = -1;
      busy_start_en = (i == 0);
      setup_clip(tbl[i].base, tbl[i].n);
      play(tbl[i].base, $sformatf("tbl%0d", i), 1'b1);
      chk($sformatf("tbl%0d.reads", i), rd_q.size(), tbl[i].exp_reads);
      chk($sformatf("tbl%0d.samples", i), tx_q.size(), tbl[i].exp_samples);
      if (tbl[i].n == 0) chk($sformatf("tbl%0d.no_valid", i), vcnt, 0);
    end
    busy_start_en = 1'b0;
    lat = 2; ready_pct = 100; pause_pct = 0;

    // Back-pressure on the second sample.
    setup_clip(23'd100, 3);
    hold_addr = 23'd102; hold_left = 10;
    play(23'd100, "stall", 1'b1);
    chk("stall.applied", hold_left, 0);

    // Pause while the first sample is on offer.
    setup_clip(23'd100, 3);
    pause_addr = 23'd101; pause_left = 5; pause_on = 1'b0;
    play(23'd100, "pause", 1'b1);
    chk("pause.applied", pause_left, 0);

    // Stop while the second sample is being fetched.
    setup_clip(23'd100, 3);
    stop_addr = 23'd102; stop_addr_en = 1'b1;
    play(23'd100, "stop_rd", 1'b0);
    chk("stop_rd.reads", rd_q.size(), 3);
    chk("stop_rd.samples", tx_q.size(), 1);
    stop_addr_en = 1'b0;

    // Stop and pause in IDLE are ignored.
    done_cnt = 0; rcyc = 0; rd_q.delete(); stop_cyc = 1; pause_pct = 100;
    repeat (4) step();
    chk("idle.no_done", done_cnt, 0);
    chk("idle.busy", play_busy, 0);
    chk("idle.no_read", rd_q.size(), 0);
    stop_cyc = -1; pause_pct = 0;

    // Asynchronous reset while a sample is on offer, then replay.
    setup_clip(23'd100, 3);
    ready_pct = 0;
    done_cnt = 0; rcyc = 0;
    play_select = 23'd100; play_start = 1'b1;
    step();
    while (!play_audio_valid && rcyc < 100) step();
    chk("arst.reached_send", play_audio_valid, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("arst.busy", play_busy, 0);
    chk("arst.valid", play_audio_valid, 0);
    chk("arst.read", play_read, 0);
    chk("arst.addr", play_addr, 0);
    chk("arst.data", play_audio_data, 0);
    #1 i_rst = 1'b0;
    in_flight = 1'b0; play_sdram_finished = 1'b0; play_audio_ready = 1'b0;
    ready_pct = 100;
    play(23'd100, "arst_replay", 1'b1);

    // Randomized clips, some with a stop at a random point.
    for (int r = 0; r < 14; r++) begin
      base = AW'($urandom());
      if (r % 4 == 0) base = 23'h7FFFFF - AW'($urandom_range(3));
      lat       = $urandom_range(1, 4);
      ready_pct = $urandom_range(30, 100);
      pause_pct = $urandom_range(0, 25);
      stop_cyc  = ($urandom_range(3) == 0) ? $urandom_range(1, 25) : -1;
      ex        = (stop_cyc < 0);
      setup_clip(base, $urandom_range(0, 5));
      play(base, $sformatf("rnd%0d", r), ex);
    end
    stop_cyc = -1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
